// File: rtl/uart_pkg.sv
// Shared types and constants for the UART port and its receive store.
package uart_pkg;

    localparam int CLK_DIV_DEFAULT = 434;
    localparam int RX_FIFO_DEPTH   = 4;
    localparam int DATA_BITS       = 8;
    localparam int STOP_BITS       = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte store. UART_PORT_RX_FIFO_EN selects a 4-entry circular FIFO;
// otherwise a single holding register. A pop frees room for a same-cycle push.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

`ifdef UART_PORT_RX_FIFO_EN
    logic [7:0] mem_q [RX_FIFO_DEPTH];
    logic [7:0] mem_d [RX_FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       do_push, do_pop;

    assign full    = (cnt_q == 3'(RX_FIFO_DEPTH));
    assign empty   = (cnt_q == 3'd0);
    assign rd_data = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 2'd1;
        if (do_push && !do_pop) cnt_d = cnt_q + 3'd1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       do_push, do_pop;

    assign full    = valid_q;
    assign empty   = !valid_q;
    assign rd_data = data_q;
    assign do_pop  = pop && valid_q;
    assign do_push = push && (!valid_q || do_pop);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (do_pop) valid_d = 1'b0;
        if (do_push) begin
            data_d  = push_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule

// File: rtl/uart_port.sv
// Bus-attached UART: strobe-driven TX holding register/shifter and an RX
// deserializer feeding uart_rx_fifo (depth set by UART_PORT_RX_FIFO_EN).
module uart_port
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wrn,
    input  logic       rdn,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       rx_err
);

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1  = 16'(CLK_DIV / 2 - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic        wrn_q, wrn_d1_q, rdn_q, rdn_d1_q;
    logic        rxd_s1_q, rxd_s2_q, rxd_d1_q;
    logic        wr_edge, rd_edge, rx_fall;

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, hold_q, hold_d, rx_shift_q, rx_shift_d;
    logic        txd_q, txd_d, tbre_q, tbre_d, tsre_q, tsre_d, rx_err_q, rx_err_d;
    logic        tx_load, rx_push, frame_err;
    logic [7:0]  fifo_rd_data;
    logic        fifo_full, fifo_empty;

    assign wr_edge = !wrn_q && wrn_d1_q;
    assign rd_edge = rdn_q && !rdn_d1_q;
    assign rx_fall = rxd_d1_q && !rxd_s2_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_state_q == ST_IDLE) ? 16'd0 : tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tsre_d     = tsre_q;
        tbre_d     = tbre_q;
        hold_d     = hold_q;
        tx_load    = 1'b0;
        if (wr_edge && tbre_q) begin
            hold_d = data_in;
            tbre_d = 1'b0;
        end
        case (tx_state_q)
            ST_IDLE:  tx_load = !tbre_q;
            ST_START: if (tx_cnt_q == DIV_M1) begin
                tx_state_d = ST_DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                txd_d      = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
            end
            ST_DATA: if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = '0;
                if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = ST_STOP;
                    txd_d      = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
            ST_STOP: if (tx_cnt_q == DIV_M1) begin
                // A byte waiting in the holding register starts with no idle gap.
                if (!tbre_q) tx_load = 1'b1;
                else begin
                    tx_state_d = ST_IDLE;
                    tsre_d     = 1'b1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        if (tx_load) begin
            tx_shift_d = hold_q;
            tbre_d     = 1'b1;
            tsre_d     = 1'b0;
            tx_state_d = ST_START;
            tx_cnt_d   = '0;
            txd_d      = 1'b0;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = ST_START;
            end
            // The fall-detect cycle counts as the first cycle of the start bit.
            ST_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rxd_s2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
                else rx_bit_d = rx_bit_q + 3'd1;
            end
            ST_STOP: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_state_d = ST_IDLE;
                rx_push    = rxd_s2_q;
                frame_err  = !rxd_s2_q;
            end
            default: rx_state_d = ST_IDLE;
        endcase
        rx_err_d = frame_err || (rx_push && fifo_full && !rd_edge);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrn_q      <= 1'b1;
            wrn_d1_q   <= 1'b1;
            rdn_q      <= 1'b1;
            rdn_d1_q   <= 1'b1;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_d1_q   <= 1'b1;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            txd_q      <= 1'b1;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            wrn_q      <= wrn;
            wrn_d1_q   <= wrn_q;
            rdn_q      <= rdn;
            rdn_d1_q   <= rdn_q;
            rxd_s1_q   <= rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_d1_q   <= rxd_s2_q;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            txd_q      <= txd_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_err_q   <= rx_err_d;
        end
    end

    uart_rx_fifo u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rd_edge),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign data_oe    = !rdn_q;
    assign data_out   = (data_oe && !fifo_empty) ? fifo_rd_data : 8'h00;
    assign data_ready = !fifo_empty;
    assign tbre       = tbre_q;
    assign tsre       = tsre_q;
    assign txd        = txd_q;
    assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_uart_port.sv
// Self-checking bench for uart_port at CLK_DIV=4: directed frames plus random
// concurrent TX/RX traffic against a queue-based reference model.
module tb_uart_port;
    import uart_pkg::*;

    localparam int DIV = 4;
`ifdef UART_PORT_RX_FIFO_EN
    localparam int DEPTH = RX_FIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, wrn, rdn, rxd;
    logic [7:0] data_in, data_out;
    logic       data_oe, data_ready, tbre, tsre, txd, rx_err;

    uart_port #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .data_ready(data_ready),
        .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor: records txd/tsre history, counts rx_err pulses, decodes frames.
    int         cyc = 0;
    int         err_seen = 0;
    logic       txd_hist  [32768];
    logic       tsre_hist [32768];
    logic [7:0] tx_got[$];
    int         tx_start_t[$];
    bit         mon_busy = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = '0;

    function automatic int hi(input int c);
        return c % 32768;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            txd_hist[hi(cyc)]  = txd;
            tsre_hist[hi(cyc)] = tsre;
            if (rx_err === 1'b1 && rst === 1'b0) err_seen++;
            if (rst === 1'b1) mon_busy = 1'b0;
            else if (!mon_busy) begin
                if (txd === 1'b0) begin
                    mon_busy = 1'b1;
                    mon_cnt  = 0;
                    tx_start_t.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == DIV / 2) chk("tx_start_bit", txd, 1'b0);
                if (mon_cnt % DIV == DIV / 2 && mon_cnt / DIV >= 1 && mon_cnt / DIV <= 8)
                    mon_sh = {txd, mon_sh[7:1]};
                if (mon_cnt == 9 * DIV + DIV / 2) begin
                    chk("tx_stop_bit", txd, 1'b1);
                    tx_got.push_back(mon_sh);
                end
                if (mon_cnt == 10 * DIV - 1) mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_in = b;
        wrn = 1'b0;
        tick(2);
        wrn = 1'b1;
        tick(2);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic oe);
        rdn = 1'b0;
        tick(2);
        b  = data_out;
        oe = data_oe;
        rdn = 1'b1;
        tick(3);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop;
        tick(DIV);
        rxd = 1'b1;
        tick(DIV);
    endtask

    task automatic wait_tbre(input string tag);
        int n = 0;
        while (tbre !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        chk(tag, tbre, 1'b1);
    endtask

    task automatic wait_tx_idle(input string tag);
        int n = 0;
        while ((tsre !== 1'b1 || mon_busy) && n < 1000) begin
            tick(1);
            n++;
        end
        chk(tag, tsre, 1'b1);
    endtask

    task automatic clear_tx();
        tx_got.delete();
        tx_start_t.delete();
    endtask

    logic [7:0] tx_exp[$];

    task automatic tx_rand();
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            wait_tbre("rand_tbre");
            tick($urandom_range(0, 30));
            write_byte(b);
            tx_exp.push_back(b);
        end
        wait_tx_idle("rand_tx_idle");
    endtask

    task automatic rx_rand();
        logic [7:0] mq[$];
        logic [7:0] b, got;
        logic       oe;
        int         exp_err = 0;
        int         op;
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 5);
            b  = 8'($urandom);
            if (op <= 2) begin
                send_frame(b, 1'b1);
                if (mq.size() < DEPTH) mq.push_back(b);
                else exp_err++;
            end else if (op == 3) begin
                send_frame(b, 1'b0);
                exp_err++;
            end else begin
                read_byte(got, oe);
                chk("rand_rd_oe", oe, 1'b1);
                chk("rand_rd_data", got, (mq.size() > 0) ? mq.pop_front() : 8'h00);
            end
            chk("rand_ready", data_ready, mq.size() > 0);
            chk("rand_err_cnt", err_seen, exp_err);
        end
        while (mq.size() > 0) begin
            read_byte(got, oe);
            chk("rand_drain", got, mq.pop_front());
        end
    endtask

    initial begin
        logic [7:0] b55, got;
        logic [39:0] gw, ew;
        logic       oe;
        int         s, e0, bi;

        rst = 1'b1; wrn = 1'b1; rdn = 1'b1; rxd = 1'b1; data_in = '0;
        tick(4);
        chk("rst_txd", txd, 1'b1);
        chk("rst_tbre", tbre, 1'b1);
        chk("rst_tsre", tsre, 1'b1);
        chk("rst_ready", data_ready, 1'b0);
        chk("rst_oe", data_oe, 1'b0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_rx_err", rx_err, 1'b0);
        rst = 1'b0;
        tick(4);

        // Single frame: exact bit-level waveform and tsre timing.
        clear_tx();
        b55 = 8'h55;
        write_byte(b55);
        wait_tx_idle("w55_idle");
        tick(2);
        chk("w55_frames", tx_got.size(), 1);
        s = (tx_start_t.size() > 0) ? tx_start_t[0] : 0;
        for (int k = 0; k < 40; k++) begin
            bi = k / DIV;
            gw[k] = txd_hist[hi(s + k)];
            ew[k] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b55[bi - 1];
        end
        chk("w55_wave", gw, ew);
        chk("w55_tsre_last_stop", tsre_hist[hi(s + 39)], 1'b0);
        chk("w55_tsre_after", tsre_hist[hi(s + 40)], 1'b1);

        // Back-to-back frames; a write while the holding register is full is lost.
        clear_tx();
        write_byte(8'h55);
        wait_tbre("b2b_tbre_rise");
        write_byte(8'hA3);
        chk("b2b_tbre_full", tbre, 1'b0);
        write_byte(8'h77);
        wait_tx_idle("b2b_idle");
        tick(2);
        chk("b2b_frames", tx_got.size(), 2);
        if (tx_got.size() == 2) begin
            chk("b2b_byte0", tx_got[0], 8'h55);
            chk("b2b_byte1", tx_got[1], 8'hA3);
            chk("b2b_gap", tx_start_t[1] - tx_start_t[0], 10 * DIV);
        end

        // Receive one frame and read it.
        err_seen = 0;
        send_frame(8'h3C, 1'b1);
        chk("rx3c_ready", data_ready, 1'b1);
        rdn = 1'b0;
        tick(2);
        chk("rx3c_dout", data_out, 8'h3C);
        chk("rx3c_oe", data_oe, 1'b1);
        rdn = 1'b1;
        tick(3);
        chk("rx3c_ready_clr", data_ready, 1'b0);
        chk("rx3c_no_err", err_seen, 0);

        // Glitch is a false start; bad stop bit is a framing error.
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        tick(3 * DIV);
        chk("glitch_ready", data_ready, 1'b0);
        chk("glitch_err", err_seen, 0);
        send_frame(8'h81, 1'b0);
        chk("frame_err_cnt", err_seen, 1);
        chk("frame_err_ready", data_ready, 1'b0);

        // Overflow: DEPTH+1 frames, one error, oldest DEPTH bytes kept.
        e0 = err_seen;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b1);
        chk("ovf_err", err_seen - e0, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            read_byte(got, oe);
            chk("ovf_read", got, 8'(i));
        end
        chk("ovf_ready_empty", data_ready, 1'b0);
        read_byte(got, oe);
        chk("empty_read_data", got, 8'h00);
        chk("empty_read_oe", oe, 1'b1);

        // Random concurrent TX and RX traffic.
        clear_tx();
        tx_exp.delete();
        err_seen = 0;
        fork
            tx_rand();
            rx_rand();
        join
        tick(2);
        chk("rand_tx_count", tx_got.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
            chk("rand_tx_byte", tx_got[i], tx_exp[i]);

        // Reset in the middle of a TX frame with a byte in the RX store.
        send_frame(8'h5A, 1'b1);
        chk("mid_rst_ready_before", data_ready, 1'b1);
        write_byte(8'hC3);
        tick(3 * DIV);
        chk("mid_rst_busy", tsre, 1'b0);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_tbre", tbre, 1'b1);
        chk("mid_rst_tsre", tsre, 1'b1);
        chk("mid_rst_ready", data_ready, 1'b0);
        rst = 1'b0;
        tick(4);
        clear_tx();
        write_byte(8'h96);
        wait_tx_idle("post_rst_idle");
        tick(2);
        chk("post_rst_frames", tx_got.size(), 1);
        if (tx_got.size() == 1) chk("post_rst_byte", tx_got[0], 8'h96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
